// File: rtl/data_mem_responder.sv
// Byte-addressed little-endian data memory behind valid/ready request and response
// channels, with a fixed access latency and RV32I load extension / store masking.
module data_mem_responder #(
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_WIDTH = 17,
  parameter int    LATENCY    = 2,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_size,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state, stateNext;
  logic [3:0]            cnt, cntNext;
  logic                  commit;
  logic                  latWrite;
  logic [2:0]            latSize;
  logic [ADDR_WIDTH-1:0] latAddr;
  logic [DATA_WIDTH-1:0] latWdata;
  logic                  opWrite, opErr;
  logic [2:0]            opSize;
  logic [ADDR_WIDTH-1:0] opAddr, opAddr1, opAddr2, opAddr3;
  logic [DATA_WIDTH-1:0] opWdata, rawWord;

  logic [7:0] mem [2**ADDR_WIDTH];

  function automatic logic accessErr(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      3'b000, 3'b100: accessErr = 1'b0;
      3'b001, 3'b101: accessErr = lo[0];
      3'b010:         accessErr = (lo != 2'b00);
      default:        accessErr = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] extendLoad(input logic [2:0] size, input logic [31:0] raw);
    logic signed [7:0]  sByte;
    logic signed [15:0] sHalf;
    sByte = raw[7:0];
    sHalf = raw[15:0];
    case (size)
      3'b000:  extendLoad = 32'(sByte);
      3'b100:  extendLoad = {24'b0, raw[7:0]};
      3'b001:  extendLoad = 32'(sHalf);
      3'b101:  extendLoad = {16'b0, raw[15:0]};
      3'b010:  extendLoad = raw;
      default: extendLoad = 32'b0;
    endcase
  endfunction

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  // With LATENCY=1 the commit edge is the acceptance edge, so take the live request.
  assign opWrite = (state == IDLE) ? req_write : latWrite;
  assign opSize  = (state == IDLE) ? req_size  : latSize;
  assign opAddr  = (state == IDLE) ? req_addr  : latAddr;
  assign opWdata = (state == IDLE) ? req_wdata : latWdata;
  assign opErr   = accessErr(opSize, opAddr[1:0]);
  assign opAddr1 = opAddr + ADDR_WIDTH'(1);
  assign opAddr2 = opAddr + ADDR_WIDTH'(2);
  assign opAddr3 = opAddr + ADDR_WIDTH'(3);
  assign rawWord = {mem[opAddr3], mem[opAddr2], mem[opAddr1], mem[opAddr]};

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    commit    = 1'b0;
    case (state)
      IDLE: if (req_valid) begin
        cntNext = 4'(LATENCY - 1);
        if (LATENCY == 1) begin
          stateNext = RESP;
          commit    = 1'b1;
        end else begin
          stateNext = WAIT;
        end
      end
      WAIT: if (cnt <= 4'd1) begin
        stateNext = RESP;
        cntNext   = 4'd0;
        commit    = 1'b1;
      end else begin
        cntNext = cnt - 4'd1;
      end
      RESP: if (resp_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && req_valid) begin
      latWrite <= req_write;
      latSize  <= req_size;
      latAddr  <= req_addr;
      latWdata <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (commit) begin
      resp_err   <= opErr;
      resp_rdata <= (opErr || opWrite) ? '0 : extendLoad(opSize, rawWord);
    end
  end

  // Stores land at the commit edge; aligned accesses never run past the top byte.
  always_ff @(posedge clk) begin
    if (!rst && commit && opWrite && !opErr) begin
      mem[opAddr] <= opWdata[7:0];
      if (opSize[1:0] != 2'b00) mem[opAddr1] <= opWdata[15:8];
      if (opSize[1:0] == 2'b10) begin
        mem[opAddr2] <= opWdata[23:16];
        mem[opAddr3] <= opWdata[31:24];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one LATENCY=2 and one LATENCY=1 instance.
module tb_data_mem_responder;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  reqValid, reqReady, reqWrite, respValid, respReady, respErr;
  logic [2:0]  reqSize [2];
  logic [16:0] reqAddr [2];
  logic [31:0] reqWdata [2];
  logic [31:0] respRdata [2];
  int          lat [2] = '{2, 1};
  exp_t        sb [$];
  int          passCnt = 0;
  int          totalCnt = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(17), .LATENCY(2), .INIT_FILE("")) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_write(reqWrite[0]),
    .req_size(reqSize[0]), .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]),
    .resp_valid(respValid[0]), .resp_ready(respReady[0]),
    .resp_rdata(respRdata[0]), .resp_err(respErr[0])
  );

  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(17), .LATENCY(1), .INIT_FILE("")) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_write(reqWrite[1]),
    .req_size(reqSize[1]), .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]),
    .resp_valid(respValid[1]), .resp_ready(respReady[1]),
    .resp_rdata(respRdata[1]), .resp_err(respErr[1])
  );

  task automatic txn(input int w, input logic wr, input logic [2:0] size, input logic [16:0] addr,
                     input logic [31:0] wdata, input logic [31:0] expData, input logic expErr,
                     input int stall, input bit holdReq);
    exp_t        e;
    int          cyc;
    logic [31:0] held;
    sb.push_back('{expErr, expData});
    @(negedge clk);
    reqValid[w] = 1'b1; reqWrite[w] = wr; reqSize[w] = size;
    reqAddr[w] = addr; reqWdata[w] = wdata;
    @(negedge clk);
    reqValid[w] = 1'b0; reqWrite[w] = 1'($urandom);
    reqAddr[w] = 17'($urandom); reqWdata[w] = $urandom;
    cyc = 1;
    while (respValid[w] !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    totalCnt++;
    if (cyc !== lat[w]) $display("FAIL latency u%0d addr=%h: got %0d cycles, expected %0d", w, addr, cyc, lat[w]);
    else passCnt++;
    held = respRdata[w];
    if (holdReq) begin
      reqValid[w] = 1'b1; reqWrite[w] = 1'b0; reqSize[w] = 3'b010; reqAddr[w] = 17'h100;
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      totalCnt++;
      if ({respValid[w], reqReady[w], respRdata[w]} !== {1'b1, 1'b0, held})
        $display("FAIL stall_hold cycle %0d: valid=%b ready=%b rdata=%h, expected 1 0 %h",
                 i, respValid[w], reqReady[w], respRdata[w], held);
      else passCnt++;
    end
    respReady[w] = 1'b1;
    e = sb.pop_front();
    totalCnt++;
    if ({respErr[w], respRdata[w]} !== {e.err, e.data})
      $display("FAIL resp u%0d addr=%h size=%b: got err=%b rdata=%h, expected err=%b rdata=%h",
               w, addr, size, respErr[w], respRdata[w], e.err, e.data);
    else passCnt++;
    @(negedge clk);
    respReady[w] = 1'b0;
    reqValid[w] = 1'b0;
    totalCnt++;
    if ({respValid[w], reqReady[w]} !== 2'b01)
      $display("FAIL return_idle u%0d: valid=%b ready=%b, expected 0 1", w, respValid[w], reqReady[w]);
    else passCnt++;
    if (holdReq) begin
      @(negedge clk);
      totalCnt++;
      if ({respValid[w], reqReady[w]} !== 2'b01)
        $display("FAIL held_req_ignored: valid=%b ready=%b, expected 0 1", respValid[w], reqReady[w]);
      else passCnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    reqValid = 2'b11; reqWrite = 2'b11; respReady = 2'b00;
    for (int i = 0; i < 2; i++) begin
      reqSize[i] = 3'b010; reqAddr[i] = 17'h40; reqWdata[i] = 32'h0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    reqValid = 2'b00;
    for (int i = 0; i < 2; i++) begin
      totalCnt++;
      if ({reqReady[i], respValid[i], respErr[i], respRdata[i]} !== {3'b100, 32'h0})
        $display("FAIL reset_values u%0d: ready=%b valid=%b err=%b rdata=%h, expected 1 0 0 0",
                 i, reqReady[i], respValid[i], respErr[i], respRdata[i]);
      else passCnt++;
    end
    repeat (3) @(negedge clk);
    totalCnt++;
    if (respValid !== 2'b00)
      $display("FAIL req_during_reset: resp_valid=%b, expected 00", respValid);
    else passCnt++;
  endtask

  task automatic test_store_load();
    txn(0, 1'b1, 3'b010, 17'h100, 32'hDEADBEEF, 32'h0, 1'b0, 0, 1'b0);
    txn(0, 1'b0, 3'b010, 17'h100, 32'h0, 32'hDEADBEEF, 1'b0, 0, 1'b0);
    txn(0, 1'b0, 3'b000, 17'h103, 32'h0, 32'hFFFFFFDE, 1'b0, 0, 1'b0);
    txn(0, 1'b0, 3'b100, 17'h103, 32'h0, 32'h000000DE, 1'b0, 0, 1'b0);
    txn(0, 1'b0, 3'b001, 17'h102, 32'h0, 32'hFFFFDEAD, 1'b0, 0, 1'b0);
    txn(0, 1'b0, 3'b101, 17'h100, 32'h0, 32'h0000BEEF, 1'b0, 0, 1'b0);
  endtask

  task automatic test_partial_store();
    txn(0, 1'b1, 3'b000, 17'h101, 32'hFFFFFF12, 32'h0, 1'b0, 0, 1'b0);
    txn(0, 1'b0, 3'b010, 17'h100, 32'h0, 32'hDEAD12EF, 1'b0, 0, 1'b0);
    txn(0, 1'b1, 3'b001, 17'h102, 32'hAAAA5678, 32'h0, 1'b0, 0, 1'b0);
    txn(0, 1'b0, 3'b010, 17'h100, 32'h0, 32'h567812EF, 1'b0, 0, 1'b0);
  endtask

  task automatic test_errors();
    txn(0, 1'b0, 3'b010, 17'h102, 32'h0, 32'h0, 1'b1, 0, 1'b0);
    txn(0, 1'b1, 3'b001, 17'h101, 32'h0000FFFF, 32'h0, 1'b1, 0, 1'b0);
    txn(0, 1'b0, 3'b011, 17'h100, 32'h0, 32'h0, 1'b1, 0, 1'b0);
    txn(0, 1'b1, 3'b110, 17'h100, 32'h11111111, 32'h0, 1'b1, 0, 1'b0);
    txn(0, 1'b0, 3'b010, 17'h100, 32'h0, 32'h567812EF, 1'b0, 0, 1'b0);
  endtask

  task automatic test_stall();
    txn(0, 1'b0, 3'b001, 17'h100, 32'h0, 32'h000012EF, 1'b0, 5, 1'b1);
  endtask

  task automatic test_top_of_memory();
    txn(0, 1'b1, 3'b010, 17'h1FFFC, 32'hCAFEF00D, 32'h0, 1'b0, 0, 1'b0);
    txn(0, 1'b0, 3'b010, 17'h1FFFC, 32'h0, 32'hCAFEF00D, 1'b0, 0, 1'b0);
    txn(0, 1'b0, 3'b000, 17'h1FFFF, 32'h0, 32'hFFFFFFCA, 1'b0, 0, 1'b0);
  endtask

  task automatic test_reset_in_wait();
    txn(0, 1'b1, 3'b010, 17'h200, 32'h0, 32'h0, 1'b0, 0, 1'b0);
    txn(0, 1'b0, 3'b010, 17'h100, 32'h0, 32'h567812EF, 1'b0, 0, 1'b0);
    @(negedge clk);
    reqValid[0] = 1'b1; reqWrite[0] = 1'b1; reqSize[0] = 3'b010;
    reqAddr[0] = 17'h200; reqWdata[0] = 32'hAAAAAAAA;
    @(negedge clk);
    reqValid[0] = 1'b0;
    totalCnt++;
    if (reqReady[0] !== 1'b0) $display("FAIL in_wait: req_ready=%b, expected 0", reqReady[0]);
    else passCnt++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    totalCnt++;
    if ({reqReady[0], respValid[0], respErr[0], respRdata[0]} !== {3'b100, 32'h0})
      $display("FAIL abort_reset: ready=%b valid=%b err=%b rdata=%h, expected 1 0 0 0",
               reqReady[0], respValid[0], respErr[0], respRdata[0]);
    else passCnt++;
    repeat (3) @(negedge clk);
    totalCnt++;
    if (respValid[0] !== 1'b0) $display("FAIL abort_no_resp: resp_valid=%b, expected 0", respValid[0]);
    else passCnt++;
    txn(0, 1'b0, 3'b010, 17'h200, 32'h0, 32'h00000000, 1'b0, 0, 1'b0);
  endtask

  task automatic test_latency_one();
    txn(1, 1'b1, 3'b010, 17'h10, 32'h11223344, 32'h0, 1'b0, 0, 1'b0);
    txn(1, 1'b0, 3'b010, 17'h10, 32'h0, 32'h11223344, 1'b0, 0, 1'b0);
    txn(1, 1'b0, 3'b101, 17'h12, 32'h0, 32'h00001122, 1'b0, 0, 1'b0);
    txn(1, 1'b0, 3'b000, 17'h10, 32'h0, 32'h00000044, 1'b0, 2, 1'b0);
    txn(1, 1'b0, 3'b001, 17'h11, 32'h0, 32'h0, 1'b1, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_partial_store();
    test_errors();
    test_stall();
    test_top_of_memory();
    test_reset_in_wait();
    test_latency_one();
    totalCnt++;
    if (sb.size() !== 0) $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
    else passCnt++;
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passCnt, totalCnt);
    $fatal(1, "timeout");
  end

endmodule
